// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
// Memory handshake FSM state encoding, the hard-wired zero register
// and the default access-timeout length (used with PIPE_MEM_TIMEOUT_EN).
package pipe_ctrl_pkg;

  // Data-memory handshake FSM states (2-bit).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Register 0 is hard-wired to zero and can never carry a hazard.
  localparam int REG_ZERO = 0;

  // Default number of REQ cycles tolerated before an access is abandoned.
  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detector.
// Flags when the instruction in EX is a load whose destination is read by
// the instruction in ID. Purely combinational; register 0 never hazards.
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] IfId_Rs,
  input  logic [REG_W-1:0] IfId_Rt,
  input  logic             IfId_UsesRt,
  input  logic             IdEx_MemRD,
  input  logic [REG_W-1:0] IdEx_WriteAddr,
  output logic             LoadUse
);

  logic dest_nonzero;
  logic rs_match;
  logic rt_match;

  // Compare the pending load destination against both ID source operands.
  always_comb begin
    dest_nonzero = (IdEx_WriteAddr != REG_W'(REG_ZERO));
    rs_match     = (IdEx_WriteAddr == IfId_Rs);
    rt_match     = IfId_UsesRt && (IdEx_WriteAddr == IfId_Rt);
    LoadUse      = IdEx_MemRD && dest_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Combines load-use stalls, taken-branch squash and a req/ack handshake
// that freezes the pipe while data memory serves the EX_MEM access.
// Optional feature macro: PIPE_MEM_TIMEOUT_EN adds a REQ-cycle counter that
// abandons an unacknowledged access after TIMEOUT_CYCLES and pulses MemError.
// dbg_state exposes the handshake FSM state.
//
// Handshake: DMemReq is a registered level, high exactly while the FSM is in
// REQ. The memory may raise DMemAck in any REQ cycle, including the first;
// the access completes on the clock edge where DMemReq && DMemAck are both
// high. DMemAck outside REQ has no effect.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
`ifdef PIPE_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic [REG_W-1:0] IfId_Rs,
  input  logic [REG_W-1:0] IfId_Rt,
  input  logic             IfId_UsesRt,
  input  logic             IdEx_MemRD,
  input  logic [REG_W-1:0] IdEx_WriteAddr,
  input  logic             ExMem_MemRD,
  input  logic             ExMem_MemWD,
  input  logic             BranchTaken,
  input  logic             DMemAck,
  output logic             DMemReq,
  output logic             PcEn,
  output logic             IfIdEn,
  output logic             IdExEn,
  output logic             ExMemEn,
  output logic             MemWbEn,
  output logic             IfIdFlush,
  output logic             IdExFlush,
  output logic             MemWbFlush,
  output logic             MemError,
  output logic [1:0]       dbg_state
);

  state_e state_q, state_d;
  logic   load_use;
  logic   mem_op;
  logic   freeze;
  logic   drop_wb;

  hazard_unit #(.REG_W(REG_W)) u_hazard (
    .IfId_Rs        (IfId_Rs),
    .IfId_Rt        (IfId_Rt),
    .IfId_UsesRt    (IfId_UsesRt),
    .IdEx_MemRD     (IdEx_MemRD),
    .IdEx_WriteAddr (IdEx_WriteAddr),
    .LoadUse        (load_use)
  );

  assign mem_op = ExMem_MemRD || ExMem_MemWD;

`ifdef PIPE_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timed_out;

  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state logic: handshake sequencing with REQ-cycle timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        if (DMemAck) begin
          state_d = ST_DONE;
        end else if (timed_out) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, REQ-cycle counter and error flag registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A timed-out access is dropped: bubble into WB during its DONE cycle.
  assign drop_wb  = err_q;
  assign MemError = err_q;
`else
  // Next-state logic: handshake sequencing, REQ waits for ack indefinitely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_op)  state_d = ST_REQ;
      ST_REQ:  if (DMemAck) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  assign drop_wb  = 1'b0;
  assign MemError = 1'b0;
`endif

  // Request follows the registered state, so an async reset drops it at once.
  assign DMemReq   = (state_q == ST_REQ);
  assign dbg_state = state_q;

  // The pipe is frozen while detecting a memory op in IDLE and throughout REQ.
  assign freeze = (state_q == ST_REQ) || ((state_q == ST_IDLE) && mem_op);

  // Output decode: reset > freeze > branch > load-use > normal.
  always_comb begin
    PcEn       = 1'b1;
    IfIdEn     = 1'b1;
    IdExEn     = 1'b1;
    ExMemEn    = 1'b1;
    MemWbEn    = 1'b1;
    IfIdFlush  = 1'b0;
    IdExFlush  = 1'b0;
    MemWbFlush = drop_wb;
    if (!Reset_n) begin
      PcEn       = 1'b0;
      IfIdEn     = 1'b0;
      IdExEn     = 1'b0;
      ExMemEn    = 1'b0;
      MemWbEn    = 1'b0;
      IfIdFlush  = 1'b1;
      IdExFlush  = 1'b1;
      MemWbFlush = 1'b1;
    end else if (freeze) begin
      PcEn       = 1'b0;
      IfIdEn     = 1'b0;
      IdExEn     = 1'b0;
      ExMemEn    = 1'b0;
      MemWbEn    = 1'b0;
      MemWbFlush = 1'b1;
    end else if (BranchTaken) begin
      // Squash wins over load-use: the stalled instruction is discarded anyway.
      IfIdFlush = 1'b1;
      IdExFlush = 1'b1;
    end else if (load_use) begin
      PcEn      = 1'b0;
      IfIdEn    = 1'b0;
      IdExFlush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// A behavioural model tracks the memory access phase at transaction level and
// derives every output from the stall/flush rules; one process compares all
// outputs on each negedge. Directed literal checks pin the model.
// Define PIPE_MEM_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_pipeline_ctrl;

  localparam int REG_W = 5;
  localparam int TMO   = 4;

  logic             clk;
  logic             Reset_n;
  logic [REG_W-1:0] IfId_Rs;
  logic [REG_W-1:0] IfId_Rt;
  logic             IfId_UsesRt;
  logic             IdEx_MemRD;
  logic [REG_W-1:0] IdEx_WriteAddr;
  logic             ExMem_MemRD;
  logic             ExMem_MemWD;
  logic             BranchTaken;
  logic             DMemAck;
  logic             DMemReq;
  logic             PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn;
  logic             IfIdFlush, IdExFlush, MemWbFlush;
  logic             MemError;
  logic [1:0]       dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  pipeline_ctrl #(
    .REG_W(REG_W)
`ifdef PIPE_MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .IfId_Rs        (IfId_Rs),
    .IfId_Rt        (IfId_Rt),
    .IfId_UsesRt    (IfId_UsesRt),
    .IdEx_MemRD     (IdEx_MemRD),
    .IdEx_WriteAddr (IdEx_WriteAddr),
    .ExMem_MemRD    (ExMem_MemRD),
    .ExMem_MemWD    (ExMem_MemWD),
    .BranchTaken    (BranchTaken),
    .DMemAck        (DMemAck),
    .DMemReq        (DMemReq),
    .PcEn           (PcEn),
    .IfIdEn         (IfIdEn),
    .IdExEn         (IdExEn),
    .ExMemEn        (ExMemEn),
    .MemWbEn        (MemWbEn),
    .IfIdFlush      (IfIdFlush),
    .IdExFlush      (IdExFlush),
    .MemWbFlush     (MemWbFlush),
    .MemError       (MemError),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- behavioural model ----------------
  // m_waiting: an access is outstanding at the memory (request visible).
  // m_release: the access just finished; the pipe gets one free cycle.
  // m_fault:   the finished access was abandoned for lack of ack.
  logic m_waiting, m_release, m_fault;
  int   m_reqs;

  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_waiting <= 1'b0;
      m_release <= 1'b0;
      m_fault   <= 1'b0;
      m_reqs    <= 0;
    end else if (m_release) begin
      m_release <= 1'b0;
      m_fault   <= 1'b0;
    end else if (m_waiting) begin
      if (DMemAck) begin
        m_waiting <= 1'b0;
        m_release <= 1'b1;
      end else begin
        m_reqs <= m_reqs + 1;
`ifdef PIPE_MEM_TIMEOUT_EN
        if (m_reqs + 1 == TMO) begin
          m_waiting <= 1'b0;
          m_release <= 1'b1;
          m_fault   <= 1'b1;
        end
`endif
      end
    end else if (ExMem_MemRD || ExMem_MemWD) begin
      m_waiting <= 1'b1;
      m_reqs    <= 0;
    end
  end

  // Outputs packed as {DMemReq, PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn,
  //                    IfIdFlush, IdExFlush, MemWbFlush, MemError}.
  function automatic logic [9:0] model_out();
    logic       frozen, hazard;
    logic [4:0] en;
    logic       fl_ifid, fl_idex, fl_memwb;
    if (!Reset_n) return 10'b0_00000_111_0;
    frozen = m_waiting ||
             (!m_release && (ExMem_MemRD || ExMem_MemWD));
    hazard = IdEx_MemRD && (IdEx_WriteAddr != 0) &&
             ((IdEx_WriteAddr == IfId_Rs) ||
              (IfId_UsesRt && (IdEx_WriteAddr == IfId_Rt)));
    en       = 5'b11111;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    fl_memwb = m_fault;
    if (frozen) begin
      en       = 5'b00000;
      fl_memwb = 1'b1;
    end else if (BranchTaken) begin
      fl_ifid = 1'b1;
      fl_idex = 1'b1;
    end else if (hazard) begin
      en[4:3] = 2'b00;
      fl_idex = 1'b1;
    end
    return {m_waiting, en, fl_ifid, fl_idex, fl_memwb, m_fault};
  endfunction

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    logic [9:0] got;
    exp_q.push_back(model_out());
    got = {DMemReq, PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn,
           IfIdFlush, IdExFlush, MemWbFlush, MemError};
    vectors++;
    if (got !== exp_q[0]) begin
      miscompares++;
      $display("FAIL cycle_outputs @%0d: got %b expected %b", cycle, got, exp_q[0]);
    end
    void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, cycle, got, exp);
    end
  endtask

  task automatic clear_inputs();
    IfId_Rs        = '0;
    IfId_Rt        = '0;
    IfId_UsesRt    = 1'b0;
    IdEx_MemRD     = 1'b0;
    IdEx_WriteAddr = '0;
    ExMem_MemRD    = 1'b0;
    ExMem_MemWD    = 1'b0;
    BranchTaken    = 1'b0;
    DMemAck        = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset_n = 1'b0;
    clear_inputs();

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_pcen",   PcEn, 0);
    chk("rst_flush",  {IfIdFlush, IdExFlush, MemWbFlush}, 3'b111);
    chk("rst_req",    DMemReq, 0);
    chk("rst_err",    MemError, 0);
    tick();
    Reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_en", {PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn}, 5'b11111);
    chk("post_rst_fl", {IfIdFlush, IdExFlush, MemWbFlush}, 3'b000);
    tick();

    // Load-use on rs
    IdEx_MemRD = 1'b1; IdEx_WriteAddr = 5'd5; IfId_Rs = 5'd5;
    @(negedge clk);
    chk("lu_pcen",  {PcEn, IfIdEn}, 2'b00);
    chk("lu_flush", IdExFlush, 1);
    chk("lu_exmem", {ExMemEn, MemWbEn}, 2'b11);
    tick();
    IdEx_MemRD = 1'b0;      // bubble cleared the load in ID_EX
    @(negedge clk);
    chk("lu_done",  PcEn, 1);
    tick();

    // Register 0 never hazards
    IdEx_MemRD = 1'b1; IdEx_WriteAddr = 5'd0; IfId_Rs = 5'd0;
    @(negedge clk);
    chk("lu_r0", {PcEn, IdExFlush}, 2'b10);
    tick();

    // rt match only counts when rt is read
    IdEx_WriteAddr = 5'd7; IfId_Rs = 5'd1; IfId_Rt = 5'd7; IfId_UsesRt = 1'b0;
    @(negedge clk);
    chk("lu_rt_unused", PcEn, 1);
    tick();
    IfId_UsesRt = 1'b1;
    @(negedge clk);
    chk("lu_rt_used", PcEn, 0);
    tick();

    // Branch beats load-use
    BranchTaken = 1'b1;
    @(negedge clk);
    chk("br_over_lu", {PcEn, IfIdFlush, IdExFlush}, 3'b111);
    tick();
    clear_inputs();

    // Memory read, ack in the third REQ cycle, branch raised during freeze
    ExMem_MemRD = 1'b1;
    @(negedge clk);
    chk("mem_idle_frz", {DMemReq, PcEn, MemWbFlush}, 3'b001);
    tick();
    BranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) DMemAck = 1'b1;
      @(negedge clk);
      chk("mem_req", {DMemReq, PcEn, MemWbFlush, IfIdFlush}, 4'b1010);
      tick();
    end
    DMemAck = 1'b0; ExMem_MemRD = 1'b0;
    @(negedge clk);
    chk("mem_done", {DMemReq, PcEn, MemWbFlush, IfIdFlush, IdExFlush}, 5'b01011);
    tick();
    BranchTaken = 1'b0;
    @(negedge clk);
    chk("mem_after", {DMemReq, PcEn}, 2'b01);
    tick();

    // Back-to-back store then load, immediate acks
    ExMem_MemWD = 1'b1;
    @(negedge clk);
    chk("b2b_st_idle", {DMemReq, PcEn}, 2'b00);
    tick();
    DMemAck = 1'b1;
    @(negedge clk);
    chk("b2b_st_req", DMemReq, 1);
    tick();
    DMemAck = 1'b0; ExMem_MemWD = 1'b0; ExMem_MemRD = 1'b1;
    @(negedge clk);
    chk("b2b_done", {DMemReq, PcEn}, 2'b01);
    tick();
    @(negedge clk);
    chk("b2b_ld_idle", {DMemReq, PcEn}, 2'b00);
    tick();
    DMemAck = 1'b1;
    @(negedge clk);
    chk("b2b_ld_req", DMemReq, 1);
    tick();
    DMemAck = 1'b0; ExMem_MemRD = 1'b0;
    @(negedge clk);
    chk("b2b_ld_done", DMemReq, 0);
    tick();

    // Stray ack in IDLE is ignored
    DMemAck = 1'b1;
    @(negedge clk);
    chk("stray_ack", {DMemReq, PcEn}, 2'b01);
    tick();
    DMemAck = 1'b0;
    @(negedge clk);
    chk("stray_ack_next", dbg_state, 2'd0);
    tick();

    // Asynchronous reset in the middle of REQ
    ExMem_MemRD = 1'b1;
    tick();
    @(negedge clk);
    chk("arst_in_req", DMemReq, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_req_drop", DMemReq, 0);
    chk("arst_en",       {PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn}, 5'b00000);
    chk("arst_flush",    {IfIdFlush, IdExFlush, MemWbFlush}, 3'b111);
    ExMem_MemRD = 1'b0;
    tick();
    Reset_n = 1'b1;
    DMemAck = 1'b1;            // late ack for the discarded access
    @(negedge clk);
    chk("arst_release", {DMemReq, PcEn, IfIdEn, IdExEn, ExMemEn, MemWbEn}, 6'b011111);
    tick();
    DMemAck = 1'b0;
    @(negedge clk);
    chk("arst_idle", dbg_state, 2'd0);
    tick();

`ifdef PIPE_MEM_TIMEOUT_EN
    // No ack: abort after TMO REQ cycles
    ExMem_MemRD = 1'b1;
    tick();
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      chk("tmo_req", {DMemReq, MemError}, 2'b10);
      tick();
    end
    ExMem_MemRD = 1'b0;
    @(negedge clk);
    chk("tmo_done", {DMemReq, MemError, MemWbFlush, PcEn}, 4'b0111);
    tick();
    @(negedge clk);
    chk("tmo_idle", {MemError, MemWbFlush}, 2'b00);
    tick();
`else
    // No ack: REQ holds well past any timeout length
    ExMem_MemRD = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    chk("wait_forever", {DMemReq, MemError, PcEn}, 3'b100);
    tick();
    DMemAck = 1'b1;
    tick();
    DMemAck = 1'b0; ExMem_MemRD = 1'b0;
    @(negedge clk);
    chk("wait_done", {DMemReq, PcEn}, 2'b01);
    tick();
`endif

    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
